apl_req_sched: RTL

// - Schedules L2 cache-line fetch requests from `channels` L2 channels onto the single OpenCAPI 3.0 request port.
// - Round-robin arbitration, gated by per-channel outstanding-request credits.
// - Routes each OpenCAPI response back to its owning channel by sid.
// - Provides a flush/drain sequence so stream reset never races in-flight fetches.
// - Sits between the L2 channels and the o_req/i_rsp interface of apl_top.

---
 rtl/apl_pkg.sv | 25 ++
 rtl/apl_rr_arb.sv | 32 +++
 rtl/apl_req_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/apl_pkg.sv
// Shared parameters, types and sid decode for the L2-to-OpenCAPI request scheduler.
package apl_pkg;

   localparam int unsigned nstrms       = 64;
   localparam int unsigned nstrms_width = $clog2(nstrms);
   localparam int unsigned l2_nstrms    = 16;
   localparam int unsigned channels     = nstrms / l2_nstrms;
   localparam int unsigned chan_width   = $clog2(channels);
   localparam int unsigned addr_width   = 64;
   localparam int unsigned max_outst    = 16;
   localparam int unsigned cnt_width    = $clog2(max_outst + 1);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} sched_state_t;

   typedef struct packed {
      logic [nstrms_width-1:0] sid;
      logic [addr_width-1:0]   ea;
   } req_t;

   // Owning L2 channel is encoded in the top bits of the stream id.
   function automatic logic [chan_width-1:0] sid_chan(input logic [nstrms_width-1:0] sid);
      return sid[nstrms_width-1 -: chan_width];
   endfunction

endpackage

// File: rtl/apl_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins; reports the pointer to use next.
module apl_rr_arb #(
   parameter int unsigned n_req = 4,
   parameter int unsigned ptr_w = $clog2(n_req)
) (
   input  logic [n_req-1:0] req,
   input  logic             en,
   input  logic [ptr_w-1:0] ptr,
   output logic [n_req-1:0] gnt,
   output logic [ptr_w-1:0] nxt_ptr
);

   int unsigned pos;
   logic        found;

   always_comb begin
      gnt     = '0;
      nxt_ptr = ptr;
      found   = 1'b0;
      pos     = 0;
      for (int unsigned i = 0; i < n_req; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= n_req) pos = pos - n_req;
         if (en && !found && req[pos[ptr_w-1:0]]) begin
            gnt[pos[ptr_w-1:0]] = 1'b1;
            found               = 1'b1;
            nxt_ptr             = (pos == n_req - 1) ? '0 : ptr_w'(pos + 1);
         end
      end
   end

endmodule

// File: rtl/apl_req_sched.sv
// Credit-gated round-robin scheduling of L2 fetch requests onto the OpenCAPI request port,
// response routing back to the owning channel, and a flush/drain handshake.
module apl_req_sched
   import apl_pkg::*;
(
   input  logic                             clk,
   input  logic                             reset,
   input  logic [channels-1:0]              i_req_v,
   output logic [channels-1:0]              i_req_r,
   input  logic [channels*nstrms_width-1:0] i_req_sid,
   input  logic [channels*addr_width-1:0]   i_req_ea,
   output logic                             o_req_v,
   input  logic                             o_req_r,
   output logic [nstrms_width-1:0]          o_req_sid,
   output logic [addr_width-1:0]            o_req_ea,
   input  logic                             i_rsp_v,
   output logic                             i_rsp_r,
   input  logic [nstrms_width-1:0]          i_rsp_sid,
   output logic [channels-1:0]              o_rsp_v,
   input  logic [channels-1:0]              o_rsp_r,
   output logic [nstrms_width-1:0]          o_rsp_sid,
   input  logic                             i_flush,
   output logic                             o_flush_done,
   output logic [channels*cnt_width-1:0]    o_outst,
   output logic                             o_err
);

   sched_state_t          state, state_nxt;
   logic [cnt_width-1:0]  cnt     [channels];
   logic [cnt_width-1:0]  cnt_nxt [channels];
   logic [channels-1:0]   elig, gnt;
   logic [chan_width-1:0] rr_ptr, rr_ptr_nxt, rsp_ch;
   logic                  arb_en, gnt_any, rsp_acc, req_v_nxt, err_nxt, all_idle;
   req_t                  sel_req, req_q;

   // New grants only while running and when the output register can take a new entry.
   assign arb_en = (state == RUN) && (!o_req_v || o_req_r);

   always_comb begin
      elig = '0;
      for (int c = 0; c < channels; c++)
         elig[c] = i_req_v[c] && (cnt[c] < cnt_width'(max_outst));
   end

   apl_rr_arb #(.n_req(channels)) u_arb (
      .req     (elig),
      .en      (arb_en),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .nxt_ptr (rr_ptr_nxt)
   );

   assign gnt_any = |gnt;
   assign i_req_r = gnt;

   always_comb begin
      sel_req = '0;
      for (int c = 0; c < channels; c++) begin
         if (gnt[c]) begin
            sel_req.sid = i_req_sid[c*nstrms_width +: nstrms_width];
            sel_req.ea  = i_req_ea[c*addr_width +: addr_width];
         end
      end
   end

   // Response demux is purely combinational.
   assign rsp_ch    = sid_chan(i_rsp_sid);
   assign i_rsp_r   = o_rsp_r[rsp_ch];
   assign o_rsp_sid = i_rsp_sid;
   assign rsp_acc   = i_rsp_v && i_rsp_r;

   always_comb begin
      o_rsp_v         = '0;
      o_rsp_v[rsp_ch] = i_rsp_v;
   end

   // A response arriving for an empty channel is a stale or bogus one: flag it, keep count at 0.
   always_comb begin
      err_nxt  = o_err;
      all_idle = 1'b1;
      for (int c = 0; c < channels; c++) begin
         cnt_nxt[c] = cnt[c];
         if (gnt[c] && !(rsp_acc && rsp_ch == chan_width'(c)))
            cnt_nxt[c] = cnt[c] + cnt_width'(1);
         else if (!gnt[c] && rsp_acc && rsp_ch == chan_width'(c)) begin
            if (cnt[c] == '0) err_nxt = 1'b1;
            else              cnt_nxt[c] = cnt[c] - cnt_width'(1);
         end
         if (cnt_nxt[c] != '0) all_idle = 1'b0;
      end
      req_v_nxt = gnt_any || (o_req_v && !o_req_r);
      if (req_v_nxt) all_idle = 1'b0;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (i_flush) state_nxt = DRAIN;
         DRAIN:   if (!i_flush) state_nxt = RUN;
                  else if (all_idle) state_nxt = DONE;
         DONE:    if (!i_flush) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= RUN;
         rr_ptr       <= '0;
         o_req_v      <= 1'b0;
         req_q        <= '0;
         o_err        <= 1'b0;
         o_flush_done <= 1'b0;
         cnt          <= '{default: '0};
      end else begin
         state        <= state_nxt;
         o_req_v      <= req_v_nxt;
         o_err        <= err_nxt;
         o_flush_done <= (state_nxt == DONE);
         cnt          <= cnt_nxt;
         if (gnt_any) begin
            rr_ptr <= rr_ptr_nxt;
            req_q  <= sel_req;
         end
      end
   end

   assign o_req_sid = req_q.sid;
   assign o_req_ea  = req_q.ea;

   always_comb begin
      o_outst = '0;
      for (int c = 0; c < channels; c++)
         o_outst[c*cnt_width +: cnt_width] = cnt[c];
   end

endmodule
